multicycle_control_unit: RTL and testbench

- Main control FSM of the 24-bit multicycle CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, plus the 2-bit ALUOp consumed directly downstream by ALUControl.
- Opcode arrives from the instruction register; a memory handshake stretches the fetch and data-access states.

---
 rtl/cpu_ctrl_pkg.sv | 65 ++++++
 rtl/control_output_decode.sv | 85 ++++++++
 rtl/multicycle_control_unit.sv | 125 ++++++++++++
 tb/tb_multicycle_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared encodings for the multicycle CPU control path: state
//               codes, opcodes, ALUOp, mux selects and the control word.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;

    // Shared with ALUControl; 2'b11 is reserved and never driven.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_ONE   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_word_t;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/control_output_decode.sv
`default_nettype none
// ============================================================================
// Module      : control_output_decode
// Description : Combinational map from FSM state to the datapath control word.
// Revision    : 1.0 - initial release
// ============================================================================
module control_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic       mem_ready_i,
    input  logic       op_illegal_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_ONE;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // PC and IR only advance once the fetch has actually completed.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = ALUSRCB_BROFF;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal_op = op_illegal_i;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUSRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule : control_output_decode
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Main control FSM of the 24-bit multicycle CPU; owns the state
//               register and next-state logic, outputs come from the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W      = 4,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                iord_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                mem_to_reg_o,
    output logic                reg_dst_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          alu_op_o,
    output logic [1:0]          pc_source_o,
    output logic                illegal_op_o,
    output logic [3:0]          state_o
);

    state_t     state_q;
    state_t     state_d;
    logic       w_mem_ready;
    logic       w_op_illegal;
    ctrl_word_t w_ctrl;

    generate
        if (USE_MEM_READY) begin : g_mem_ready
            assign w_mem_ready = mem_ready_i;
        end else begin : g_mem_always_ready
            assign w_mem_ready = 1'b1;
        end
    endgenerate

    always_comb begin
        w_op_illegal = 1'b1;
        case (opcode_i)
            OPCODE_W'(OP_RTYPE),
            OPCODE_W'(OP_LW),
            OPCODE_W'(OP_SW),
            OPCODE_W'(OP_BEQ),
            OPCODE_W'(OP_ADDI),
            OPCODE_W'(OP_J):    w_op_illegal = 1'b0;
            default:            w_op_illegal = 1'b1;
        endcase
    end

    // Async reset also kills any write decoded from the aborted state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH:     if (w_mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OPCODE_W'(OP_LW),
                    OPCODE_W'(OP_SW):    state_d = S_MEM_ADDR;
                    OPCODE_W'(OP_RTYPE): state_d = S_EXECUTE;
                    OPCODE_W'(OP_BEQ):   state_d = S_BRANCH;
                    OPCODE_W'(OP_ADDI):  state_d = S_ADDI_EX;
                    OPCODE_W'(OP_J):     state_d = S_JUMP;
                    default:             state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode_i == OPCODE_W'(OP_SW)) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (w_mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (w_mem_ready) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    control_output_decode u_decode (
        .state_i      (state_q),
        .mem_ready_i  (w_mem_ready),
        .op_illegal_i (w_op_illegal),
        .ctrl_o       (w_ctrl)
    );

    assign pc_write_o      = w_ctrl.pc_write;
    assign pc_write_cond_o = w_ctrl.pc_write_cond;
    assign iord_o          = w_ctrl.iord;
    assign mem_read_o      = w_ctrl.mem_read;
    assign mem_write_o     = w_ctrl.mem_write;
    assign ir_write_o      = w_ctrl.ir_write;
    assign mem_to_reg_o    = w_ctrl.mem_to_reg;
    assign reg_dst_o       = w_ctrl.reg_dst;
    assign reg_write_o     = w_ctrl.reg_write;
    assign alu_src_a_o     = w_ctrl.alu_src_a;
    assign alu_src_b_o     = w_ctrl.alu_src_b;
    assign alu_op_o        = w_ctrl.alu_op;
    assign pc_source_o     = w_ctrl.pc_source;
    assign illegal_op_o    = w_ctrl.illegal_op;
    assign state_o         = state_q;

endmodule : multicycle_control_unit
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Table-driven, scoreboarded bench for the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2;
    localparam logic [3:0] ST_MADDR = 4'd3,  ST_MREAD = 4'd4,  ST_MWB    = 4'd5;
    localparam logic [3:0] ST_MWRT  = 4'd6,  ST_EXE   = 4'd7,  ST_AWB    = 4'd8;
    localparam logic [3:0] ST_BR    = 4'd9,  ST_AEX   = 4'd10, ST_IWB    = 4'd11;
    localparam logic [3:0] ST_JMP   = 4'd12;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [16:0] act;

    typedef struct {
        logic [3:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] out;
        string       name;
    } row_t;

    row_t vec[$];
    row_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [16:0] e_fetch, e_fetch_w, e_dec, e_dec_ill, e_maddr, e_mrd, e_mwb;
    logic [16:0] e_mwr, e_exe, e_awb, e_br, e_aex, e_iwb, e_jmp;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPCODE_W(4), .USE_MEM_READY(1'b1)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .opcode_i        (opcode),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .iord_o          (iord),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .mem_to_reg_o    (mem_to_reg),
        .reg_dst_o       (reg_dst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .pc_source_o     (pc_source),
        .illegal_op_o    (illegal_op),
        .state_o         (state)
    );

    assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal_op};

    function automatic logic [16:0] mk(
        input logic pcw, input logic pcwc, input logic io, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rd,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic [1:0] pcs, input logic ill);
        return {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    function automatic void add(input logic [3:0] op, input logic rdy,
                                input logic [3:0] st, input logic [16:0] out,
                                input string nm);
        row_t r;
        r.op = op; r.rdy = rdy; r.st = st; r.out = out; r.name = nm;
        vec.push_back(r);
    endfunction

    task automatic check(input string nm, input logic [3:0] st_exp, input logic [16:0] out_exp);
        n_cmp++;
        if (state !== st_exp) begin
            n_bad++;
            $display("FAIL %s state: got %0d want %0d", nm, state, st_exp);
        end
        n_cmp++;
        if (act !== out_exp) begin
            n_bad++;
            $display("FAIL %s outputs: got %b want %b", nm, act, out_exp);
        end
    endtask

    task automatic step(input row_t r);
        row_t e;
        @(negedge clk);
        opcode    = r.op;
        mem_ready = r.rdy;
        sb.push_back(r);
        #1;
        e = sb.pop_front();
        check(e.name, e.st, e.out);
    endtask

    // Structural invariants, checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_cmp++;
            if ((mem_read && mem_write) || (reg_write && (pc_write || pc_write_cond))) begin
                n_bad++;
                $display("FAIL invariant: mr=%b mw=%b rw=%b pcw=%b pcwc=%b",
                         mem_read, mem_write, reg_write, pc_write, pc_write_cond);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        //                pcw pcwc io mr mw irw m2r rd rw asa asb    aop    pcs    ill
        e_fetch   = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        e_fetch_w = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        e_dec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
        e_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1);
        e_maddr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        e_mrd     = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_mwb     = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        e_mwr     = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_exe     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
        e_awb     = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        e_br      = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
        e_aex     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        e_iwb     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        e_jmp     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);

        // R-type: 4 cycles
        add(4'h0, 1, ST_FETCH,  e_fetch,   "r_fetch");
        add(4'h0, 1, ST_DECODE, e_dec,     "r_decode");
        add(4'h0, 1, ST_EXE,    e_exe,     "r_execute");
        add(4'h0, 1, ST_AWB,    e_awb,     "r_alu_wb");
        // LW with three wait cycles in MEM_READ: 8 cycles
        add(4'h1, 1, ST_FETCH,  e_fetch,   "lw_fetch");
        add(4'h1, 1, ST_DECODE, e_dec,     "lw_decode");
        add(4'h1, 1, ST_MADDR,  e_maddr,   "lw_mem_addr");
        add(4'h1, 0, ST_MREAD,  e_mrd,     "lw_mem_read_w1");
        add(4'h1, 0, ST_MREAD,  e_mrd,     "lw_mem_read_w2");
        add(4'h1, 0, ST_MREAD,  e_mrd,     "lw_mem_read_w3");
        add(4'h1, 1, ST_MREAD,  e_mrd,     "lw_mem_read_rdy");
        add(4'h1, 1, ST_MWB,    e_mwb,     "lw_mem_wb");
        // SW with one fetch stall
        add(4'h2, 0, ST_FETCH,  e_fetch_w, "sw_fetch_wait");
        add(4'h2, 1, ST_FETCH,  e_fetch,   "sw_fetch");
        add(4'h2, 1, ST_DECODE, e_dec,     "sw_decode");
        add(4'h2, 1, ST_MADDR,  e_maddr,   "sw_mem_addr");
        add(4'h2, 1, ST_MWRT,   e_mwr,     "sw_mem_write");
        // BEQ, MemReady low where it must be ignored
        add(4'h3, 1, ST_FETCH,  e_fetch,   "beq_fetch");
        add(4'h3, 0, ST_DECODE, e_dec,     "beq_decode");
        add(4'h3, 0, ST_BR,     e_br,      "beq_branch");
        // ADDI
        add(4'h4, 1, ST_FETCH,  e_fetch,   "addi_fetch");
        add(4'h4, 1, ST_DECODE, e_dec,     "addi_decode");
        add(4'h4, 0, ST_AEX,    e_aex,     "addi_ex");
        add(4'h4, 1, ST_IWB,    e_iwb,     "addi_wb");
        // J
        add(4'h5, 1, ST_FETCH,  e_fetch,   "j_fetch");
        add(4'h5, 1, ST_DECODE, e_dec,     "j_decode");
        add(4'h5, 1, ST_JMP,    e_jmp,     "j_jump");
        // Illegal opcodes: DECODE only, back to FETCH
        add(4'hF, 1, ST_FETCH,  e_fetch,   "ill_f_fetch");
        add(4'hF, 1, ST_DECODE, e_dec_ill, "ill_f_decode");
        add(4'h6, 1, ST_FETCH,  e_fetch,   "ill_6_fetch");
        add(4'h6, 1, ST_DECODE, e_dec_ill, "ill_6_decode");
        add(4'h0, 0, ST_FETCH,  e_fetch_w, "ill_back_fetch");

        rst = 1'b0; opcode = 4'h0; mem_ready = 1'b1;
        #1 rst = 1'b1;
        #3 check("reset_assert", ST_RESET, 17'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_release_hold", ST_RESET, 17'd0);

        foreach (vec[i]) step(vec[i]);

        // SW aborted by reset while stalled in MEM_WRITE
        add(4'h2, 1, ST_FETCH,  e_fetch,   "abort_fetch");
        add(4'h2, 1, ST_DECODE, e_dec,     "abort_decode");
        add(4'h2, 1, ST_MADDR,  e_maddr,   "abort_mem_addr");
        add(4'h2, 0, ST_MWRT,   e_mwr,     "abort_mem_write");
        for (int i = vec.size() - 4; i < vec.size(); i++) step(vec[i]);
        #2 rst = 1'b1;
        #1 check("abort_async_reset", ST_RESET, 17'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort_release_hold", ST_RESET, 17'd0);
        add(4'h0, 1, ST_FETCH, e_fetch, "abort_resume_fetch");
        step(vec[vec.size() - 1]);
        add(4'h0, 1, ST_DECODE, e_dec, "abort_resume_decode");
        step(vec[vec.size() - 1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_multicycle_control_unit
`default_nettype wire
